digdug_hvgen: RTL

Video timing generator for the DigDug core. Divides CLK48M into a 6 MHz pixel-clock enable and runs the horizontal/vertical position counters POSH/POSV that feed the video stage, sprite engine and CPU interrupt logic. Also generates blanking, sync and a VBLANK interrupt strobe for the CPU. Sync placement can be trimmed per frame.

---
 rtl/digdug_video_pkg.sv | 25 ++
 rtl/digdug_hvgen_if.sv | 31 +++
 rtl/digdug_hv_window.sv | 40 ++++
 rtl/digdug_hvgen.sv | 121 ++++++++++++
 4 files changed

// File: rtl/digdug_video_pkg.sv
`default_nettype none
// ============================================================================
// digdug_video_pkg : DigDug screen geometry, sync placement and position types
// Rev 1.0
// ============================================================================
package digdug_video_pkg;

    localparam int H_TOTAL  = 384;
    localparam int H_ACTIVE = 288;
    localparam int V_TOTAL  = 264;
    localparam int V_ACTIVE = 224;
    localparam int HS_START = 320;
    localparam int HS_WIDTH = 32;
    localparam int VS_START = 240;
    localparam int VS_WIDTH = 4;

    typedef logic [8:0]        pos_t;
    typedef logic signed [8:0] ofs_t;

    function automatic ofs_t trim_sext(input logic [3:0] t);
        return {{5{t[3]}}, t};
    endfunction

endpackage
`default_nettype wire

// File: rtl/digdug_hvgen_if.sv
`default_nettype none
// ============================================================================
// digdug_hvgen_if : video timing bundle between generator and video consumers
// Rev 1.0
// ============================================================================
interface digdug_hvgen_if;
    import digdug_video_pkg::*;

    logic [3:0] HTRIM;
    logic [3:0] VTRIM;
    logic       PCE;
    pos_t       POSH;
    pos_t       POSV;
    logic       HBLK;
    logic       VBLK;
    logic       HSYNC;
    logic       VSYNC;
    logic       VBIRQ;
    logic       FIELD;

    modport master (
        input  HTRIM, VTRIM,
        output PCE, POSH, POSV, HBLK, VBLK, HSYNC, VSYNC, VBIRQ, FIELD
    );

    modport slave (
        output HTRIM, VTRIM,
        input  PCE, POSH, POSV, HBLK, VBLK, HSYNC, VSYNC, VBIRQ, FIELD
    );
endinterface
`default_nettype wire

// File: rtl/digdug_hv_window.sv
`default_nettype none
// ============================================================================
// digdug_hv_window : registered [START+ofs, START+ofs+WIDTH-1] window comparator
// Rev 1.0
// ============================================================================
module digdug_hv_window
    import digdug_video_pkg::*;
#(
    parameter int START = 0,
    parameter int WIDTH = 1
) (
    input  logic CLK48M,
    input  logic RST_N,
    input  pos_t pos_d_i,
    input  ofs_t ofs_i,
    output logic win_o
);
    logic signed [10:0] pos_s;
    logic signed [10:0] lo;
    logic signed [10:0] hi;
    logic               win_q;

    // Widened to 11 bits so a negative offset cannot alias onto a large position.
    always_comb begin
        pos_s = signed'({2'b00, pos_d_i});
        lo    = signed'(11'(START)) + signed'({{2{ofs_i[8]}}, ofs_i});
        hi    = lo + signed'(11'(WIDTH - 1));
    end

    always_ff @(posedge CLK48M or negedge RST_N) begin
        if (!RST_N) begin
            win_q <= 1'b0;
        end else begin
            win_q <= (pos_s >= lo) && (pos_s <= hi);
        end
    end

    assign win_o = win_q;
endmodule
`default_nettype wire

// File: rtl/digdug_hvgen.sv
`default_nettype none
// ============================================================================
// digdug_hvgen : 6 MHz pixel enable, POSH/POSV counters, blank/sync/VBLANK IRQ.
// Optional per-frame sync trim is built only when HVGEN_TRIM_EN is defined.
// Rev 1.0
// ============================================================================
module digdug_hvgen
    import digdug_video_pkg::*;
#(
    parameter int P_H_TOTAL  = H_TOTAL,
    parameter int P_H_ACTIVE = H_ACTIVE,
    parameter int P_V_TOTAL  = V_TOTAL,
    parameter int P_V_ACTIVE = V_ACTIVE,
    parameter int P_HS_START = HS_START,
    parameter int P_HS_WIDTH = HS_WIDTH,
    parameter int P_VS_START = VS_START,
    parameter int P_VS_WIDTH = VS_WIDTH
) (
    input  logic           CLK48M,
    input  logic           RST_N,
    digdug_hvgen_if.master vid
);
    logic [2:0] div_q;
    pos_t       posh_q, posh_d;
    pos_t       posv_q, posv_d;
    logic       field_q, field_d;
    logic       hblk_q, vblk_q, vbirq_q;
    logic       pce, h_wrap, v_wrap;
    ofs_t       ht_d, vt_d;
    logic       hsync, vsync;

    assign pce = (div_q == 3'd7);

    always_comb begin
        posh_d  = posh_q;
        posv_d  = posv_q;
        field_d = field_q;
        h_wrap  = pce && (posh_q == pos_t'(P_H_TOTAL - 1));
        v_wrap  = h_wrap && (posv_q == pos_t'(P_V_TOTAL - 1));
        if (pce) begin
            posh_d = h_wrap ? '0 : posh_q + 1'b1;
        end
        if (h_wrap) begin
            posv_d = v_wrap ? '0 : posv_q + 1'b1;
        end
        if (v_wrap) begin
            field_d = ~field_q;
        end
    end

    // Decoded outputs follow the next position so they line up with POSH/POSV.
    always_ff @(posedge CLK48M or negedge RST_N) begin
        if (!RST_N) begin
            div_q   <= '0;
            posh_q  <= '0;
            posv_q  <= '0;
            field_q <= 1'b0;
            hblk_q  <= 1'b0;
            vblk_q  <= 1'b0;
            vbirq_q <= 1'b0;
        end else begin
            div_q   <= div_q + 3'd1;
            posh_q  <= posh_d;
            posv_q  <= posv_d;
            field_q <= field_d;
            hblk_q  <= (posh_d >= pos_t'(P_H_ACTIVE));
            vblk_q  <= (posv_d >= pos_t'(P_V_ACTIVE));
            vbirq_q <= (posv_d == pos_t'(P_V_ACTIVE)) && (posh_d == '0);
        end
    end

`ifdef HVGEN_TRIM_EN
    ofs_t ht_q, vt_q;

    // Trims only move at frame entry so a mid-frame change never tears sync.
    always_ff @(posedge CLK48M or negedge RST_N) begin
        if (!RST_N) begin
            ht_q <= '0;
            vt_q <= '0;
        end else if (v_wrap) begin
            ht_q <= trim_sext(vid.HTRIM);
            vt_q <= trim_sext(vid.VTRIM);
        end
    end

    assign ht_d = v_wrap ? trim_sext(vid.HTRIM) : ht_q;
    assign vt_d = v_wrap ? trim_sext(vid.VTRIM) : vt_q;
`else
    logic unused_trim;
    assign unused_trim = ^{vid.HTRIM, vid.VTRIM};
    assign ht_d        = '0;
    assign vt_d        = '0;
`endif

    digdug_hv_window #(.START(P_HS_START), .WIDTH(P_HS_WIDTH)) u_hs_win (
        .CLK48M  (CLK48M),
        .RST_N   (RST_N),
        .pos_d_i (posh_d),
        .ofs_i   (ht_d),
        .win_o   (hsync)
    );

    digdug_hv_window #(.START(P_VS_START), .WIDTH(P_VS_WIDTH)) u_vs_win (
        .CLK48M  (CLK48M),
        .RST_N   (RST_N),
        .pos_d_i (posv_d),
        .ofs_i   (vt_d),
        .win_o   (vsync)
    );

    assign vid.PCE   = pce;
    assign vid.POSH  = posh_q;
    assign vid.POSV  = posv_q;
    assign vid.HBLK  = hblk_q;
    assign vid.VBLK  = vblk_q;
    assign vid.HSYNC = hsync;
    assign vid.VSYNC = vsync;
    assign vid.VBIRQ = vbirq_q;
    assign vid.FIELD = field_q;
endmodule
`default_nettype wire
